// File: rtl/note_dropper_param.sv
// One falling rhythm-game note: waits for the start key, falls at a fixed speed, and
// resolves to HIT (graded) or MISS. It exposes its position and a 40x40 arrow bitmap.
module note_dropper_param #(
  parameter logic [7:0]  LANE_KEY    = 8'h04,
  parameter logic [9:0]  X_START     = 10'd40,
  parameter logic [9:0]  Y_START     = 10'd100,
  parameter logic [9:0]  Y_MAX       = 10'd400,
  parameter logic [9:0]  HIT_TOP     = 10'd340,
  parameter logic [9:0]  PERF_LO     = 10'd360,
  parameter logic [9:0]  PERF_HI     = 10'd380,
  parameter logic [11:0] START_DELAY = 12'd1760,
  parameter logic [9:0]  SPEED       = 10'd1,
  parameter logic [1:0]  DIR         = 2'd0
) (
  input  logic          frame_clk,
  input  logic          Reset,
  input  logic [7:0]    keycode,
  input  logic [7:0]    keycode_second,
  output logic [9:0]    dropX,
  output logic [9:0]    dropY,
  output logic [1599:0] sprite,
  output logic          hit,
  output logic          miss,
  output logic [1:0]    grade,
  output logic          done_pulse
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_FALL = 3'd2,
    S_HIT  = 3'd3,
    S_MISS = 3'd4
  } state_t;

  localparam logic [7:0]  KEY_START = 8'h2C;
  localparam logic [7:0]  KEY_CLEAR = 8'h01;
  localparam logic [9:0]  SPRITE_H  = 10'd40;
  localparam int          SPRITE_W  = 32'sd40;
  // Highest Y the note may reach: its bottom then sits at most SPEED past Y_MAX.
  localparam logic [10:0] Y_CAP     = {1'b0, Y_MAX} + {1'b0, SPEED} - 11'd40;

  state_t        state_q, state_d;
  logic [9:0]    y_q, y_d;
  logic [11:0]   cnt_q, cnt_d;
  logic [1:0]    grade_q, grade_d;
  logic          hit_q, hit_d;
  logic          miss_q, miss_d;
  logic          done_q, done_d;
  logic          key_prev_q;
  logic          key_now_s;
  logic          key_fresh_s;
  logic          resolved_q_s;
  logic          resolved_d_s;
  logic [10:0]   bottom_s;
  logic [10:0]   y_sum_s;
  logic [1599:0] arrow_s;

  assign key_now_s    = (keycode == LANE_KEY) || (keycode_second == LANE_KEY);
  assign key_fresh_s  = key_now_s && !key_prev_q;
  assign bottom_s     = {1'b0, y_q} + {1'b0, SPRITE_H};
  assign y_sum_s      = {1'b0, y_q} + {1'b0, SPEED};
  assign resolved_q_s = (state_q == S_HIT) || (state_q == S_MISS);
  assign resolved_d_s = (state_d == S_HIT) || (state_d == S_MISS);

  // Next-state, position, delay counter and grade decisions.
  always_comb begin
    state_d = state_q;
    y_d     = y_q;
    cnt_d   = cnt_q;
    grade_d = grade_q;
    case (state_q)
      S_IDLE: begin
        y_d     = Y_START;
        cnt_d   = 12'd0;
        grade_d = 2'd0;
        if (keycode == KEY_START) begin
          if (START_DELAY == 12'd0) begin
            state_d = S_FALL;
          end else begin
            state_d = S_WAIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + 12'd1;
        if (cnt_q == START_DELAY - 12'd1) begin
          state_d = S_FALL;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_FALL: begin
        // A miss outranks a hit detected on the same frame.
        if (bottom_s >= {1'b0, Y_MAX}) begin
          state_d = S_MISS;
          grade_d = 2'd0;
        end else if (key_fresh_s && (bottom_s >= {1'b0, HIT_TOP})) begin
          state_d = S_HIT;
          if ((bottom_s >= {1'b0, PERF_LO}) && (bottom_s < {1'b0, PERF_HI})) begin
            grade_d = 2'd2;
          end else begin
            grade_d = 2'd1;
          end
        end else begin
          if (y_sum_s > Y_CAP) begin
            y_d = Y_CAP[9:0];
          end else begin
            y_d = y_sum_s[9:0];
          end
        end
      end
      S_HIT, S_MISS: begin
        if (keycode == KEY_CLEAR) begin
          state_d = S_IDLE;
          y_d     = Y_START;
          grade_d = 2'd0;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        y_d     = Y_START;
        cnt_d   = 12'd0;
        grade_d = 2'd0;
      end
    endcase
    hit_d  = (state_d == S_HIT);
    miss_d = (state_d == S_MISS);
    done_d = resolved_d_s && !resolved_q_s;
  end

  // State and output registers; Reset is synchronous and overrides everything.
  always_ff @(posedge frame_clk) begin
    if (Reset) begin
      state_q    <= S_IDLE;
      y_q        <= Y_START;
      cnt_q      <= 12'd0;
      grade_q    <= 2'd0;
      hit_q      <= 1'b0;
      miss_q     <= 1'b0;
      done_q     <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      grade_q    <= grade_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      done_q     <= done_d;
      key_prev_q <= key_now_s;
    end
  end

  // Each output pixel looks up the base up-arrow pixel it is mapped from.
  for (genvar r = 0; r < SPRITE_W; r++) begin : g_row
    for (genvar c = 0; c < SPRITE_W; c++) begin : g_col
      localparam logic [5:0] R6 = 6'(r);
      localparam logic [5:0] C6 = 6'(c);
      localparam logic [5:0] SR = (DIR == 2'd0) ? R6 :
                                  (DIR == 2'd1) ? (6'd39 - R6) : C6;
      localparam logic [5:0] SC = (DIR == 2'd0) ? C6 :
                                  (DIR == 2'd1) ? C6 :
                                  (DIR == 2'd2) ? R6 : (6'd39 - R6);
      localparam logic ON = ((SR >= 6'd10) && (SR <= 6'd17) &&
                             (SC >= 6'd29 - SR) && (SC <= SR + 6'd10)) ||
                            ((SR >= 6'd18) && (SR <= 6'd29) &&
                             (SC >= 6'd16) && (SC <= 6'd23));
      assign arrow_s[r*SPRITE_W + c] = ON;
    end
  end

  // The bitmap is blanked once the note has resolved.
  always_comb begin
    if (resolved_q_s) begin
      sprite = '0;
    end else begin
      sprite = arrow_s;
    end
  end

  assign dropX      = X_START;
  assign dropY      = y_q;
  assign hit        = hit_q;
  assign miss       = miss_q;
  assign grade      = grade_q;
  assign done_pulse = done_q;

endmodule

// File: tb/tb_note_dropper_param.sv
// Self-checking bench: four differently parameterised notes share one stimulus stream and
// are compared every frame against a behavioural model, plus hand-computed expectations.
module tb_note_dropper_param;

  localparam int N = 4;
  localparam int P_SD  [N] = '{4, 4, 4, 0};
  localparam int P_SPD [N] = '{1, 7, 1, 3};
  localparam int P_DIR [N] = '{0, 0, 2, 3};

  logic          frame_clk;
  logic          rst;
  logic [7:0]    kc, kc2;
  logic [9:0]    dx [N];
  logic [9:0]    dy [N];
  logic [1599:0] sp [N];
  logic          hit [N];
  logic          miss [N];
  logic [1:0]    grade [N];
  logic          done [N];

  int errors = 0;
  int checks = 0;

  // model: phase 0 idle, 1 waiting, 2 falling, 3 hit, 4 missed
  int            m_phase [N];
  int            m_left  [N];
  int            m_y     [N];
  int            m_grade [N];
  bit            m_done  [N];
  bit            m_prev;
  logic [1599:0] m_art   [N];

  for (genvar g = 0; g < N; g++) begin : g_dut
    note_dropper_param #(
      .START_DELAY((g == 3) ? 12'd0 : 12'd4),
      .SPEED((g == 1) ? 10'd7 : ((g == 3) ? 10'd3 : 10'd1)),
      .DIR((g == 2) ? 2'd2 : ((g == 3) ? 2'd3 : 2'd0))
    ) u_dut (
      .frame_clk(frame_clk), .Reset(rst), .keycode(kc), .keycode_second(kc2),
      .dropX(dx[g]), .dropY(dy[g]), .sprite(sp[g]), .hit(hit[g]), .miss(miss[g]),
      .grade(grade[g]), .done_pulse(done[g])
    );
  end

  initial begin
    frame_clk = 1'b0;
    forever #5 frame_clk = ~frame_clk;
  end

  function automatic bit in_arrow(int r, int c);
    int d;
    d = 2*c - 39;
    if (d < 0) d = -d;
    return ((r >= 10) && (r <= 17) && (d <= 2*r - 19)) ||
           ((r >= 18) && (r <= 29) && (c >= 16) && (c <= 23));
  endfunction

  // scatter each base pixel to where the orientation puts it
  function automatic logic [1599:0] build_art(int dir);
    logic [1599:0] a;
    a = '0;
    for (int r = 0; r < 40; r++) begin
      for (int c = 0; c < 40; c++) begin
        if (in_arrow(r, c)) begin
          case (dir)
            0:       a[r*40 + c] = 1'b1;
            1:       a[(39 - r)*40 + c] = 1'b1;
            2:       a[c*40 + r] = 1'b1;
            default: a[(39 - c)*40 + r] = 1'b1;
          endcase
        end
      end
    end
    return a;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %0d expected %0d at %0t", nm, inst, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input logic [7:0] a, input logic [7:0] b);
    bit key, fresh;
    int bot;
    key   = (a == 8'h04) || (b == 8'h04);
    fresh = key && !m_prev;
    for (int i = 0; i < N; i++) begin
      if (r) begin
        m_phase[i] = 0; m_y[i] = 100; m_grade[i] = 0; m_done[i] = 0;
      end else begin
        m_done[i] = 0;
        case (m_phase[i])
          0: begin
            m_y[i] = 100; m_grade[i] = 0;
            if (a == 8'h2C) begin
              if (P_SD[i] == 0) m_phase[i] = 2;
              else begin m_phase[i] = 1; m_left[i] = P_SD[i]; end
            end
          end
          1: begin
            m_left[i]--;
            if (m_left[i] == 0) m_phase[i] = 2;
          end
          2: begin
            bot = m_y[i] + 40;
            if (bot >= 400) begin
              m_phase[i] = 4; m_grade[i] = 0; m_done[i] = 1;
            end else if (fresh && bot >= 340) begin
              m_phase[i] = 3; m_done[i] = 1;
              m_grade[i] = (bot >= 360 && bot < 380) ? 2 : 1;
            end else begin
              m_y[i] = m_y[i] + P_SPD[i];
              if (m_y[i] > 360 + P_SPD[i]) m_y[i] = 360 + P_SPD[i];
            end
          end
          default: begin
            if (a == 8'h01) begin m_phase[i] = 0; m_y[i] = 100; m_grade[i] = 0; end
          end
        endcase
      end
    end
    m_prev = r ? 1'b0 : key;
  endtask

  task automatic compare_all();
    logic [1599:0] exp;
    int fb;
    for (int i = 0; i < N; i++) begin
      chk("dropX", i, dx[i], 40);
      chk("dropY", i, dy[i], m_y[i]);
      chk("hit", i, hit[i], (m_phase[i] == 3));
      chk("miss", i, miss[i], (m_phase[i] == 4));
      chk("grade", i, grade[i], m_grade[i]);
      chk("done_pulse", i, done[i], m_done[i]);
      exp = (m_phase[i] >= 3) ? '0 : m_art[i];
      checks++;
      if (sp[i] !== exp) begin
        errors++;
        fb = 0;
        for (int b = 0; b < 1600; b++) begin
          if (sp[i][b] !== exp[b]) begin fb = b; break; end
        end
        $display("FAIL sprite[%0d]: bit %0d got %b expected %b at %0t", i, fb, sp[i][fb], exp[fb], $time);
      end
    end
  endtask

  task automatic cycle(input bit r, input logic [7:0] a, input logic [7:0] b);
    rst = r; kc = a; kc2 = b;
    @(posedge frame_clk);
    model_step(r, a, b);
    @(negedge frame_clk);
    compare_all();
  endtask

  initial begin
    int n, dcnt;
    bit hit_seen;
    int sel;
    logic [7:0] a, b;
    for (int i = 0; i < N; i++) m_art[i] = build_art(P_DIR[i]);
    m_prev = 1'b0;

    cycle(1'b1, 8'h00, 8'h00);
    cycle(1'b1, 8'h00, 8'h00);
    chk("rst_dropY", 0, dy[0], 100);
    chk("rst_hit", 0, hit[0], 0);
    chk("rst_miss", 0, miss[0], 0);
    chk("rst_grade", 0, grade[0], 0);
    chk("rst_done", 0, done[0], 0);
    chk("art_up_tip", 0, sp[0][419], 1);
    chk("art_up_r10c18", 0, sp[0][418], 0);
    chk("art_up_shaft", 0, sp[0][29*40+16], 1);
    chk("art_tr_r19c10", 2, sp[2][770], 1);
    chk("art_tr_r10c19", 2, sp[2][419], 0);

    // plain fall to a miss
    cycle(1'b0, 8'h2C, 8'h00);
    repeat (4) cycle(1'b0, 8'h00, 8'h00);
    chk("wait_y", 0, dy[0], 100);
    cycle(1'b0, 8'h00, 8'h00);
    chk("fall1_y", 0, dy[0], 101);
    chk("fall1_y_spd7", 1, dy[1], 107);
    n = 0; dcnt = 0;
    while (miss[0] !== 1'b1 && n < 600) begin
      cycle(1'b0, 8'h00, 8'h00);
      if (done[0] === 1'b1) dcnt++;
      n++;
    end
    chk("miss_reached", 0, miss[0], 1);
    chk("miss_y", 0, dy[0], 360);
    chk("miss_grade", 0, grade[0], 0);
    cycle(1'b0, 8'h00, 8'h00);
    if (done[0] === 1'b1) dcnt++;
    chk("miss_done_count", 0, dcnt, 1);
    chk("miss_y_spd7", 1, dy[1], 366);
    chk("miss_spd7", 1, miss[1], 1);
    cycle(1'b0, 8'h01, 8'h00);
    chk("clear_y_spd7", 1, dy[1], 100);
    chk("clear_miss", 0, miss[0], 0);

    // good hit at bottom 350
    cycle(1'b0, 8'h2C, 8'h00);
    n = 0;
    while (dy[0] !== 10'd310 && n < 600) begin cycle(1'b0, 8'h00, 8'h00); n++; end
    chk("reach_y310", 0, dy[0], 310);
    cycle(1'b0, 8'h04, 8'h00);
    chk("good_hit", 0, hit[0], 1);
    chk("good_grade", 0, grade[0], 1);
    chk("good_y", 0, dy[0], 310);
    chk("good_sprite_zero", 0, (sp[0] == '0), 1);
    cycle(1'b0, 8'h00, 8'h00);
    chk("good_y_held", 0, dy[0], 310);
    cycle(1'b0, 8'h01, 8'h00);

    // perfect hit from the second key input at bottom 365
    cycle(1'b0, 8'h2C, 8'h00);
    n = 0;
    while (dy[0] !== 10'd325 && n < 600) begin cycle(1'b0, 8'h00, 8'h00); n++; end
    chk("reach_y325", 0, dy[0], 325);
    cycle(1'b0, 8'h00, 8'h04);
    chk("perf_hit", 0, hit[0], 1);
    chk("perf_grade", 0, grade[0], 2);
    cycle(1'b0, 8'h01, 8'h00);

    // lane key held from idle never counts as a press
    cycle(1'b0, 8'h2C, 8'h04);
    n = 0; hit_seen = 1'b0;
    while (miss[0] !== 1'b1 && n < 600) begin
      cycle(1'b0, 8'h00, 8'h04);
      if (hit[0] === 1'b1) hit_seen = 1'b1;
      n++;
    end
    chk("held_no_hit", 0, hit_seen, 0);
    chk("held_miss", 0, miss[0], 1);
    chk("held_miss_y", 0, dy[0], 360);
    cycle(1'b0, 8'h01, 8'h00);

    // reset in the middle of a fall
    cycle(1'b0, 8'h2C, 8'h00);
    repeat (20) cycle(1'b0, 8'h00, 8'h00);
    chk("midfall_y", 0, dy[0], 116);
    cycle(1'b1, 8'h00, 8'h00);
    chk("midrst_y", 0, dy[0], 100);
    chk("midrst_done", 0, done[0], 0);
    chk("midrst_miss", 0, miss[0], 0);
    cycle(1'b0, 8'h00, 8'h00);
    chk("midrst_done2", 0, done[0], 0);
    chk("midrst_idle_y", 0, dy[0], 100);

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      sel = $urandom_range(0, 99);
      if (sel < 4) a = 8'h2C;
      else if (sel < 9) a = 8'h04;
      else if (sel < 10) a = 8'h01;
      else if (sel < 12) a = 8'($urandom);
      else a = 8'h00;
      sel = $urandom_range(0, 99);
      if (sel < 6) b = 8'h04;
      else if (sel < 8) b = 8'($urandom);
      else b = 8'h00;
      cycle(($urandom_range(0, 499) == 0), a, b);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
